// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alu_serial_ctrl
//  Purpose  : Bit-serial sequencer for an external combinational 1-bit ALU.
//             Walks WIDTH operand bits LSB first, chains the ALU carry from
//             one bit to the next and assembles the full-width result.
//  Revision : 1.0  initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [2:0]       op_sel,
    input  logic             op_mode,
    input  logic             carry_in,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [2:0]       alu_opsel,
    output logic             alu_mode,
    input  logic             alu_out,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam int              c_CW   = $clog2(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_sel;
    logic              r_mode;
    logic              r_cin0;
    logic              r_carry;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_result;
    logic              r_cout;
    logic              w_run;
    logic              w_last;

    assign w_run  = (r_state == S_RUN);
    assign w_last = (r_cnt == c_LAST);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: start only matters in IDLE, DONE lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, bit-serial result assembly and carry chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= '0;
            r_mode   <= 1'b0;
            r_cin0   <= 1'b0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a      <= op_a;
                        r_b      <= op_b;
                        r_sel    <= op_sel;
                        r_mode   <= op_mode;
                        r_cin0   <= carry_in;
                        r_cnt    <= '0;
                        r_result <= '0;
                    end
                end
                S_RUN: begin
                    r_result[r_cnt] <= alu_out;
                    r_carry         <= alu_cout;
                    r_cnt           <= r_cnt + 1'b1;
                    // The carry leaving the top bit is the one being
                    // returned right now, not the one from the bit below.
                    if (w_last) begin
                        r_cout <= alu_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    // ALU drive: data bits and carry are forced low outside RUN.
    assign alu_a     = w_run & r_a[r_cnt];
    assign alu_b     = w_run & r_b[r_cnt];
    assign alu_cin   = w_run & ((r_cnt == '0) ? r_cin0 : r_carry);
    assign alu_opsel = r_sel;
    assign alu_mode  = r_mode;

    // Status and result outputs.
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;
    assign carry_out = r_cout;
    assign zero      = ~|r_result;

endmodule
`default_nettype wire
